// File: rtl/serial_word_rx.sv
// Serial-in, parallel-out word receiver: start bit, WIDTH data bits, stop bit,
// one bit per bit_en strobe. Good frames update o with a valid pulse.
module serial_word_rx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             bit_en,
  input  logic             sin,
  output logic [WIDTH-1:0] o,
  output logic             valid,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic [WIDTH-1:0] sh_shift_s;

  // Shift direction is fixed at elaboration; both forms stay in range for WIDTH >= 2.
  always_comb begin
    if (MSB_FIRST) begin
      sh_shift_s = {sh_q[WIDTH-2:0], sin};
    end else begin
      sh_shift_s = {sin, sh_q[WIDTH-1:1]};
    end
  end

  // Next-state and output decode; everything holds unless a strobe arrives.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (bit_en) begin
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = {CW{1'b0}};
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          sh_d  = sh_shift_s;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
          end
        end
        S_STOP: begin
          // A bad stop bit drops the frame; no resync hunt, just back to IDLE.
          if (sin) begin
            o_d     = sh_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_IDLE;
      sh_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      o_q     <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign o         = o_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx: LSB-first and MSB-first instances share
// one stimulus stream and are checked against hand-computed expectations.
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic       bit_en = 1'b0;
  logic       sin = 1'b1;
  logic [3:0] o_l, o_m;
  logic       valid_l, valid_m, ferr_l, ferr_m, busy_l, busy_m;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .bit_en(bit_en), .sin(sin),
    .o(o_l), .valid(valid_l), .frame_err(ferr_l), .busy(busy_l)
  );

  serial_word_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .bit_en(bit_en), .sin(sin),
    .o(o_m), .valid(valid_m), .frame_err(ferr_m), .busy(busy_m)
  );

  typedef struct {
    logic       clr;
    logic       en;
    logic       s;
    logic [3:0] eo_l;
    logic [3:0] eo_m;
    logic       ev;
    logic       ef;
    logic       eb;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic clr, input logic en, input logic s,
                     input logic [3:0] eo_l, input logic [3:0] eo_m,
                     input logic ev, input logic ef, input logic eb);
    vec_t v;
    v.clr = clr; v.en = en; v.s = s;
    v.eo_l = eo_l; v.eo_m = eo_m; v.ev = ev; v.ef = ef; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk1(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eo_l, input logic [3:0] eo_m,
                           input logic ev, input logic ef, input logic eb);
    chk1({tag, " o_lsb"}, o_l, eo_l);
    chk1({tag, " o_msb"}, o_m, eo_m);
    chk1({tag, " valid_lsb"}, {3'b000, valid_l}, {3'b000, ev});
    chk1({tag, " valid_msb"}, {3'b000, valid_m}, {3'b000, ev});
    chk1({tag, " ferr_lsb"}, {3'b000, ferr_l}, {3'b000, ef});
    chk1({tag, " ferr_msb"}, {3'b000, ferr_m}, {3'b000, ef});
    chk1({tag, " busy_lsb"}, {3'b000, busy_l}, {3'b000, eb});
    chk1({tag, " busy_msb"}, {3'b000, busy_m}, {3'b000, eb});
  endtask

  task automatic step(input logic clr, input logic en, input logic s);
    clear = clr; bit_en = en; sin = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with sin toggling
    add(1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    // Frame 0,1,0,1,1,1 -> LSB-first 4'hD, MSB-first 4'hB
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 4'hB, 1'b1, 1'b0, 1'b0);
    // Idle bit, then sin low without a strobe must not start a frame
    add(1'b0, 1'b1, 1'b1, 4'hD, 4'hB, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 1'b0);
    // All-zero frame: framing error, o held
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 4'hB, 1'b0, 1'b1, 1'b0);
    // Frame 0,0,1,1,0,1 -> 4'h6 both orders
    add(1'b0, 1'b1, 1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'hD, 4'hB, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 1'b1, 1'b0, 1'b0);
    // Back-to-back: 4'hF then 4'h0 with no idle bit
    add(1'b0, 1'b1, 1'b0, 4'h6, 4'h6, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
    // Abort mid-frame by clear (strobe with sin=0 present but overridden)
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    // Full frame with data 1,0,0,1 -> 4'h9 both orders
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b1, 4'h9, 4'h9, 1'b1, 1'b0, 1'b0);

    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].en, vecs[i].s);
      check_all($sformatf("vec%0d", i), vecs[i].eo_l, vecs[i].eo_m,
                vecs[i].ev, vecs[i].ef, vecs[i].eb);
    end

    // Sparse strobes: frame 0,1,0,1,1,1 with bit_en every 3rd cycle and
    // sin scrambled on the unstrobed cycles; result lands 3x later.
    begin
      logic [5:0] bits;
      bits = 6'b111010; // bit 0 is sent first
      for (int c = 1; c <= 18; c++) begin
        int b;
        logic strobe;
        b = (c - 1) / 3;
        strobe = ((c % 3) == 0);
        step(1'b0, strobe, strobe ? bits[b] : ~bits[b]);
        check_all($sformatf("sparse%0d", c),
                  (c == 18) ? 4'hD : 4'h9, (c == 18) ? 4'hB : 4'h9,
                  (c == 18), 1'b0, (c >= 3) && (c < 18));
      end
      // valid is a single-cycle pulse; o holds afterwards
      step(1'b0, 1'b0, 1'b0);
      check_all("sparse_after", 4'hD, 4'hB, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1);
      check_all("sparse_idle", 4'hD, 4'hB, 1'b0, 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
